bcd_updown_counter: RTL and testbench

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

---
 rtl/bcd_updown_counter_pkg.sv | 15 +
 rtl/bcd_updown_counter_digit.sv | 32 +++
 rtl/bcd_updown_counter.sv | 81 ++++++++
 tb/tb_bcd_updown_counter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants for the BCD up/down counter slice: decade width, digit limit
// and end-of-range mode selectors.
package bcd_updown_counter_pkg;

    localparam int                     BCD_DIGIT_W   = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic logic digit_ok(input logic [BCD_DIGIT_W-1:0] d);
        return d <= BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// One BCD decade: registered digit with a combinational carry/borrow out, so a
// chain of decades ripples within a single cycle.
module bcd_digit
    import bcd_updown_counter_pkg::*;
(
    input  logic                   ck,
    input  logic                   reset,
    input  logic                   load,
    input  logic [BCD_DIGIT_W-1:0] load_digit,
    input  logic                   inc_in,
    input  logic                   dec_in,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   carry_out,
    output logic                   borrow_out
);

    assign carry_out  = inc_in && (digit == BCD_MAX_DIGIT);
    assign borrow_out = dec_in && (digit == '0);

    // inc_in and dec_in are never both high; the top resolves conflicts.
    always_ff @(posedge ck) begin
        if (!reset)
            digit <= '0;
        else if (load)
            digit <= load_digit;
        else if (inc_in)
            digit <= carry_out ? '0 : digit + 4'd1;
        else if (dec_in)
            digit <= borrow_out ? BCD_MAX_DIGIT : digit - 4'd1;
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded BCD up/down counter with parallel load, wrap or saturate at the ends
// of range, and registered carry/borrow/load-error pulses.
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic                          ck,
    input  logic                          reset,
    input  logic                          inc,
    input  logic                          dec,
    input  logic                          load,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] load_val,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          cout,
    output logic                          bout,
    output logic                          at_max,
    output logic                          at_zero,
    output logic                          load_err
);

    localparam logic SAT_MODE = (SATURATE == MODE_SAT);

    logic [DIGITS-1:0] inc_c, dec_c, carry, borrow;
    logic valid, load_ok, load_bad, step_up, step_dn, up_go, dn_go;

    always_comb begin
        valid = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++)
            if (!digit_ok(load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
                valid = 1'b0;
    end

    assign load_ok  = load && valid;
    assign load_bad = load && !valid;

    assign at_max  = (bcd == {DIGITS{BCD_MAX_DIGIT}});
    assign at_zero = (bcd == '0);

    // Any load request, valid or not, masks stepping for that cycle.
    assign step_up = !load && inc && !dec;
    assign step_dn = !load && dec && !inc;
    assign up_go   = step_up && !(SAT_MODE && at_max);
    assign dn_go   = step_dn && !(SAT_MODE && at_zero);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_first
            assign inc_c[i] = up_go;
            assign dec_c[i] = dn_go;
        end else begin : g_next
            assign inc_c[i] = carry[i-1];
            assign dec_c[i] = borrow[i-1];
        end

        bcd_digit u_digit (
            .ck        (ck),
            .reset     (reset),
            .load      (load_ok),
            .load_digit(load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .inc_in    (inc_c[i]),
            .dec_in    (dec_c[i]),
            .digit     (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .carry_out (carry[i]),
            .borrow_out(borrow[i])
        );
    end

    always_ff @(posedge ck) begin
        if (!reset) begin
            cout     <= 1'b0;
            bout     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            cout     <= carry[DIGITS-1];
            bout     <= borrow[DIGITS-1];
            load_err <= load_bad;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: a 2-digit wrap counter, a 2-digit saturating counter sharing
// its inputs, and two 1-digit counters cascaded through cout.
module tb_bcd_updown_counter;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic       reset, inc, dec, load;
    logic [7:0] load_val;
    logic [7:0] bcd, s_bcd;
    logic       cout, bout, at_max, at_zero, load_err;
    logic       s_cout, s_bout, s_at_max, s_at_zero, s_load_err;
    logic       c_inc;
    logic [3:0] ca_bcd, cb_bcd, cb_load_val;
    logic       ca_cout, ca_bout, ca_at_max, ca_at_zero, ca_load_err;
    logic       cb_cout, cb_bout, cb_at_max, cb_at_zero, cb_load_err;
    logic       c_dec, c_load;

    int errors = 0;
    int checks = 0;

    bcd_updown_counter #(.DIGITS(2), .SATURATE(0)) dut_wrap (
        .ck(ck), .reset(reset), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
        .bcd(bcd), .cout(cout), .bout(bout), .at_max(at_max), .at_zero(at_zero),
        .load_err(load_err)
    );

    bcd_updown_counter #(.DIGITS(2), .SATURATE(1)) dut_sat (
        .ck(ck), .reset(reset), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
        .bcd(s_bcd), .cout(s_cout), .bout(s_bout), .at_max(s_at_max), .at_zero(s_at_zero),
        .load_err(s_load_err)
    );

    bcd_updown_counter #(.DIGITS(1), .SATURATE(0)) dut_ca (
        .ck(ck), .reset(reset), .inc(c_inc), .dec(c_dec), .load(c_load), .load_val(cb_load_val),
        .bcd(ca_bcd), .cout(ca_cout), .bout(ca_bout), .at_max(ca_at_max), .at_zero(ca_at_zero),
        .load_err(ca_load_err)
    );

    bcd_updown_counter #(.DIGITS(1), .SATURATE(0)) dut_cb (
        .ck(ck), .reset(reset), .inc(ca_cout), .dec(c_dec), .load(c_load), .load_val(cb_load_val),
        .bcd(cb_bcd), .cout(cb_cout), .bout(cb_bout), .at_max(cb_at_max), .at_zero(cb_at_zero),
        .load_err(cb_load_err)
    );

    task automatic step;
        @(posedge ck);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v; inc = 1'b0; dec = 1'b0;
        step;
        load = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; inc = 1'b1; dec = 1'b0; load = 1'b1; load_val = 8'h3A;
        c_inc = 1'b1; c_dec = 1'b0; c_load = 1'b0; cb_load_val = 4'h0;
        step;
        checks++; if (bcd !== 8'h00) begin errors++; $display("FAIL reset_bcd got=%h exp=00", bcd); end
        checks++; if ({cout, bout, load_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {cout, bout, load_err}); end
        checks++; if ({at_zero, at_max} !== 2'b10) begin errors++; $display("FAIL reset_flags got=%b exp=10", {at_zero, at_max}); end
        checks++; if (ca_bcd !== 4'h0) begin errors++; $display("FAIL reset_cascade got=%h exp=0", ca_bcd); end
        c_inc = 1'b0;
    endtask

    task automatic test_count_up;
        int pulses;
        logic [7:0] exp;
        pulses = 0;
        reset = 1'b1; load = 1'b0; dec = 1'b0; inc = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step;
            exp = {4'((k % 100) / 10), 4'(k % 10)};
            if (cout === 1'b1) pulses++;
            checks++; if (bcd !== exp) begin errors++; $display("FAIL up_bcd k=%0d got=%h exp=%h", k, bcd, exp); end
            checks++; if (cout !== (k == 100)) begin errors++; $display("FAIL up_cout k=%0d got=%b exp=%b", k, cout, (k == 100)); end
            if (k == 99) begin
                checks++; if (at_max !== 1'b1) begin errors++; $display("FAIL up_at_max got=%b exp=1", at_max); end
            end
        end
        inc = 1'b0;
        step;
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL up_cout_after got=%b exp=0", cout); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL up_pulse_count got=%0d exp=1", pulses); end
    endtask

    task automatic test_count_down;
        logic [7:0] exp_tab [6];
        exp_tab = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99};
        do_load(8'h05);
        checks++; if (bcd !== 8'h05) begin errors++; $display("FAIL dn_load got=%h exp=05", bcd); end
        dec = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step;
            checks++; if (bcd !== exp_tab[k]) begin errors++; $display("FAIL dn_bcd k=%0d got=%h exp=%h", k, bcd, exp_tab[k]); end
            checks++; if (bout !== (k == 5)) begin errors++; $display("FAIL dn_bout k=%0d got=%b exp=%b", k, bout, (k == 5)); end
        end
        dec = 1'b0;
        do_load(8'h10);
        dec = 1'b1;
        step;
        dec = 1'b0;
        checks++; if (bcd !== 8'h09) begin errors++; $display("FAIL dn_inner_borrow got=%h exp=09", bcd); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL dn_inner_bout got=%b exp=0", bout); end
    endtask

    task automatic test_saturate;
        do_load(8'h99);
        inc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step;
            checks++; if (s_bcd !== 8'h99) begin errors++; $display("FAIL sat_hi_bcd k=%0d got=%h exp=99", k, s_bcd); end
            checks++; if (s_cout !== 1'b0) begin errors++; $display("FAIL sat_hi_cout k=%0d got=%b exp=0", k, s_cout); end
        end
        inc = 1'b0;
        do_load(8'h00);
        dec = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step;
            checks++; if (s_bcd !== 8'h00) begin errors++; $display("FAIL sat_lo_bcd k=%0d got=%h exp=00", k, s_bcd); end
            checks++; if (s_bout !== 1'b0) begin errors++; $display("FAIL sat_lo_bout k=%0d got=%b exp=0", k, s_bout); end
        end
        dec = 1'b0;
    endtask

    task automatic test_load_err;
        do_load(8'h21);
        load = 1'b1; load_val = 8'h3A; inc = 1'b1;
        step;
        load = 1'b0; inc = 1'b0;
        checks++; if (bcd !== 8'h21) begin errors++; $display("FAIL lerr_bcd got=%h exp=21", bcd); end
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL lerr_pulse got=%b exp=1", load_err); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL lerr_cout got=%b exp=0", cout); end
        step;
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL lerr_once got=%b exp=0", load_err); end
        do_load(8'h42);
        checks++; if (bcd !== 8'h42) begin errors++; $display("FAIL lerr_good_load got=%h exp=42", bcd); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL lerr_good_flag got=%b exp=0", load_err); end
    endtask

    task automatic test_inc_dec_both;
        do_load(8'h57);
        inc = 1'b1; dec = 1'b1;
        step;
        inc = 1'b0; dec = 1'b0;
        checks++; if (bcd !== 8'h57) begin errors++; $display("FAIL both_bcd got=%h exp=57", bcd); end
        checks++; if ({cout, bout} !== 2'b00) begin errors++; $display("FAIL both_pulses got=%b exp=00", {cout, bout}); end
    endtask

    task automatic test_reset_wrap;
        do_load(8'h99);
        inc = 1'b1; reset = 1'b0;
        step;
        checks++; if (bcd !== 8'h00) begin errors++; $display("FAIL rstwrap_bcd got=%h exp=00", bcd); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL rstwrap_cout got=%b exp=0", cout); end
        reset = 1'b1; inc = 1'b0;
        step;
        checks++; if ({cout, bout} !== 2'b00) begin errors++; $display("FAIL rstwrap_after got=%b exp=00", {cout, bout}); end
        checks++; if ({at_zero, at_max} !== 2'b10) begin errors++; $display("FAIL rstwrap_flags got=%b exp=10", {at_zero, at_max}); end
    endtask

    task automatic test_cascade;
        reset = 1'b0;
        step;
        reset = 1'b1; c_inc = 1'b1;
        for (int k = 0; k < 25; k++) step;
        c_inc = 1'b0;
        step;
        step;
        checks++; if (ca_bcd !== 4'h5) begin errors++; $display("FAIL cascade_lo got=%h exp=5", ca_bcd); end
        checks++; if (cb_bcd !== 4'h2) begin errors++; $display("FAIL cascade_hi got=%h exp=2", cb_bcd); end
    endtask

    initial begin
        test_reset;
        test_count_up;
        test_count_down;
        test_saturate;
        test_load_err;
        test_inc_dec_both;
        test_reset_wrap;
        test_cascade;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
